// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one FIFO write port among NREQ requesters
module fifo_wr_arbiter #(
   parameter int DW        = 8,
   parameter int NREQ      = 4,
   parameter int MAX_BURST = 4,
   localparam int OW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic               w_clk,
   input  logic               w_rst_n,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ-1:0]    req_last,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   input  logic               full,
   output logic               w_en,
   output logic [DW-1:0]      w_data,
   output logic [OW-1:0]      owner,
   output logic               busy
);

   localparam int CW = $clog2(MAX_BURST) + 1;

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [OW-1:0] owner_nxt;
   logic [OW-1:0] rr_ptr;
   logic [OW-1:0] rr_nxt;
   logic [OW-1:0] rr_adv;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [OW-1:0] pick;
   logic [OW:0]   idx;
   logic          any_req;
   logic          own_valid;
   logic          own_last;
   logic [DW-1:0] own_data;
   logic          xfer;

   // Round-robin pick: first valid requester scanning upward from rr_ptr with wrap
   always_comb begin
      pick    = '0;
      any_req = 1'b0;
      idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = {1'b0, rr_ptr} + (OW+1)'(k);
         if (idx >= (OW+1)'(NREQ)) begin
            idx = idx - (OW+1)'(NREQ);
         end
         if (!any_req && req_valid[idx[OW-1:0]]) begin
            pick    = idx[OW-1:0];
            any_req = 1'b1;
         end
      end
   end

   // Select the current owner's request lines
   always_comb begin
      own_valid = 1'b0;
      own_last  = 1'b0;
      own_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (owner == OW'(i)) begin
            own_valid = req_valid[i];
            own_last  = req_last[i];
            own_data  = req_data[i*DW +: DW];
         end
      end
   end

   // Round-robin pointer moves just past the owner whenever a grant ends
   always_comb begin
      rr_adv = (owner == OW'(NREQ-1)) ? '0 : owner + OW'(1);
   end

   // State register: FSM state, grant owner, round-robin pointer, burst word count
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state  <= IDLE;
         owner  <= '0;
         rr_ptr <= '0;
         cnt    <= '0;
      end else begin
         state  <= state_nxt;
         owner  <= owner_nxt;
         rr_ptr <= rr_nxt;
         cnt    <= cnt_nxt;
      end
   end

   // Next state: grant in IDLE, count words in BURST, release on last/limit/valid drop
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      rr_nxt    = rr_ptr;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_nxt = BURST;
               owner_nxt = pick;
               cnt_nxt   = '0;
            end
         end
         BURST: begin
            if (!own_valid) begin
               // A vanished request releases the grant even while the FIFO is full
               state_nxt = IDLE;
               rr_nxt    = rr_adv;
            end else if (xfer) begin
               cnt_nxt = cnt + CW'(1);
               if (own_last || (cnt == CW'(MAX_BURST-1))) begin
                  state_nxt = IDLE;
                  rr_nxt    = rr_adv;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: write straight through from the owner, blocked by full, only in BURST
   always_comb begin
      busy      = (state == BURST);
      xfer      = busy & own_valid & ~full;
      w_en      = xfer;
      w_data    = own_data;
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = xfer && (owner == OW'(i));
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

   logic        w_clk;
   logic        w_rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_last;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        full;
   logic        w_en;
   logic [7:0]  w_data;
   logic [1:0]  owner;
   logic        busy;

   fifo_wr_arbiter #(.DW(8), .NREQ(4), .MAX_BURST(4)) dut (
      .w_clk     (w_clk),
      .w_rst_n   (w_rst_n),
      .req_valid (req_valid),
      .req_last  (req_last),
      .req_data  (req_data),
      .req_ready (req_ready),
      .full      (full),
      .w_en      (w_en),
      .w_data    (w_data),
      .owner     (owner),
      .busy      (busy)
   );

   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;

   int tests = 0;
   int fails = 0;

   // Requester sources: {last, data} words per requester
   logic [8:0] mem [4][32];
   int         head [4];
   int         tail [4];
   logic [3:0] en_mask;
   logic       full_r;
   logic [7:0] wlog [64];
   int         wcnt;
   logic [15:0] obs;
   logic [15:0] exp_v;

   // {busy, w_en, owner, req_ready, data-if-written}
   function automatic logic [15:0] pack_obs();
      return {busy, w_en, owner, req_ready, (w_en ? w_data : 8'h00)};
   endfunction

   task automatic push(input int r, input logic [7:0] d, input logic l);
      mem[r][tail[r]] = {l, d};
      tail[r]++;
   endtask

   task automatic step();
      @(negedge w_clk);
      for (int i = 0; i < 4; i++) begin
         req_valid[i]        = en_mask[i] && (head[i] != tail[i]);
         req_data[i*8 +: 8]  = mem[i][head[i]][7:0];
         req_last[i]         = mem[i][head[i]][8];
      end
      full = full_r;
      #1;
      obs = pack_obs();
      for (int i = 0; i < 4; i++) begin
         if (req_ready[i]) head[i]++;
      end
      if (w_en) begin
         wlog[wcnt] = w_data;
         wcnt++;
      end
   endtask

   task automatic do_reset();
      w_rst_n   = 1'b0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      full      = 1'b0;
      full_r    = 1'b0;
      en_mask   = 4'hF;
      wcnt      = 0;
      for (int i = 0; i < 4; i++) begin
         head[i] = 0;
         tail[i] = 0;
         for (int j = 0; j < 32; j++) mem[i][j] = '0;
      end
      repeat (2) @(posedge w_clk);
      @(negedge w_clk);
      w_rst_n = 1'b1;
   endtask

   task automatic test_reset();
      w_rst_n = 1'b0;
      req_valid = 4'hF;
      #1;
      tests++;
      if (pack_obs() !== 16'h0000) begin
         fails++;
         $display("FAIL reset_outputs got %h exp %h", pack_obs(), 16'h0000);
      end
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      push(0, 8'd100, 1'b0);
      push(0, 8'd101, 1'b0);
      push(0, 8'd102, 1'b1);
      for (int c = 0; c < 5; c++) begin
         step();
         case (c)
            0:       exp_v = {1'b0, 1'b0, 2'd0, 4'b0000, 8'd0};
            4:       exp_v = {1'b0, 1'b0, 2'd0, 4'b0000, 8'd0};
            default: exp_v = {1'b1, 1'b1, 2'd0, 4'b0001, 8'(100 + c - 1)};
         endcase
         tests++;
         if (obs !== exp_v) begin
            fails++;
            $display("FAIL single_c%0d got %h exp %h", c, obs, exp_v);
         end
      end
   endtask

   task automatic test_round_robin();
      int slot, pos, o;
      do_reset();
      for (int r = 0; r < 4; r++)
         for (int j = 0; j < 8; j++) push(r, 8'(r*16 + j), 1'b0);
      for (int c = 0; c < 25; c++) begin
         step();
         slot = c / 5;
         pos  = c % 5;
         if (pos == 0) begin
            o = (slot == 0) ? 0 : (slot - 1) % 4;
            exp_v = {1'b0, 1'b0, 2'(o), 4'b0000, 8'd0};
         end else begin
            o = slot % 4;
            exp_v = {1'b1, 1'b1, 2'(o), 4'(1 << o), 8'(o*16 + ((slot == 4) ? 4 : 0) + pos - 1)};
         end
         tests++;
         if (obs !== exp_v) begin
            fails++;
            $display("FAIL rr_c%0d got %h exp %h", c, obs, exp_v);
         end
      end
   endtask

   task automatic test_full_stall();
      do_reset();
      for (int j = 0; j < 4; j++) push(2, 8'(32 + j), 1'b0);
      for (int c = 0; c < 9; c++) begin
         full_r = (c >= 3 && c <= 5);
         step();
         case (c)
            0:          exp_v = {1'b0, 1'b0, 2'd0, 4'b0000, 8'd0};
            1:          exp_v = {1'b1, 1'b1, 2'd2, 4'b0100, 8'd32};
            2:          exp_v = {1'b1, 1'b1, 2'd2, 4'b0100, 8'd33};
            3, 4, 5:    exp_v = {1'b1, 1'b0, 2'd2, 4'b0000, 8'd0};
            6:          exp_v = {1'b1, 1'b1, 2'd2, 4'b0100, 8'd34};
            7:          exp_v = {1'b1, 1'b1, 2'd2, 4'b0100, 8'd35};
            default:    exp_v = {1'b0, 1'b0, 2'd2, 4'b0000, 8'd0};
         endcase
         tests++;
         if (obs !== exp_v) begin
            fails++;
            $display("FAIL full_c%0d got %h exp %h", c, obs, exp_v);
         end
      end
   endtask

   task automatic test_rr_pointer();
      do_reset();
      push(1, 8'h50, 1'b1);
      for (int c = 0; c < 6; c++) begin
         if (c == 2) begin
            push(0, 8'h60, 1'b1);
            push(1, 8'h61, 1'b1);
         end
         step();
         case (c)
            0:       exp_v = {1'b0, 1'b0, 2'd0, 4'b0000, 8'd0};
            1:       exp_v = {1'b1, 1'b1, 2'd1, 4'b0010, 8'h50};
            2:       exp_v = {1'b0, 1'b0, 2'd1, 4'b0000, 8'd0};
            3:       exp_v = {1'b1, 1'b1, 2'd0, 4'b0001, 8'h60};
            4:       exp_v = {1'b0, 1'b0, 2'd0, 4'b0000, 8'd0};
            default: exp_v = {1'b1, 1'b1, 2'd1, 4'b0010, 8'h61};
         endcase
         tests++;
         if (obs !== exp_v) begin
            fails++;
            $display("FAIL rrptr_c%0d got %h exp %h", c, obs, exp_v);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      push(3, 8'h70, 1'b0);
      push(3, 8'h71, 1'b0);
      push(3, 8'h72, 1'b1);
      step();
      step();
      tests++;
      exp_v = {1'b1, 1'b1, 2'd3, 4'b1000, 8'h70};
      if (obs !== exp_v) begin
         fails++;
         $display("FAIL rstmid_first got %h exp %h", obs, exp_v);
      end
      @(negedge w_clk);
      #2;
      w_rst_n = 1'b0;
      #1;
      tests++;
      if (pack_obs() !== 16'h0000) begin
         fails++;
         $display("FAIL rstmid_async got %h exp %h", pack_obs(), 16'h0000);
      end
      push(0, 8'hA0, 1'b1);
      @(posedge w_clk);
      #2;
      w_rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         case (c)
            0:       exp_v = {1'b0, 1'b0, 2'd0, 4'b0000, 8'd0};
            1:       exp_v = {1'b1, 1'b1, 2'd0, 4'b0001, 8'hA0};
            2:       exp_v = {1'b0, 1'b0, 2'd0, 4'b0000, 8'd0};
            default: exp_v = {1'b1, 1'b1, 2'd3, 4'b1000, 8'h71};
         endcase
         tests++;
         if (obs !== exp_v) begin
            fails++;
            $display("FAIL rstmid_c%0d got %h exp %h", c, obs, exp_v);
         end
      end
   endtask

   task automatic test_drop_end_to_end();
      do_reset();
      en_mask = 4'b0110;
      push(1, 8'd100, 1'b0);
      push(1, 8'd101, 1'b0);
      for (int j = 0; j < 4; j++) push(2, 8'(102 + j), 1'b0);
      push(0, 8'd106, 1'b0);
      push(0, 8'd107, 1'b1);
      for (int c = 0; c < 40; c++) begin
         if (c == 3) en_mask[0] = 1'b1;
         full_r = (wcnt >= 8);
         step();
         if (c == 3) begin
            tests++;
            exp_v = {1'b1, 1'b0, 2'd1, 4'b0000, 8'd0};
            if (obs !== exp_v) begin
               fails++;
               $display("FAIL drop_release got %h exp %h", obs, exp_v);
            end
         end
         if (c == 5) begin
            tests++;
            exp_v = {1'b1, 1'b1, 2'd2, 4'b0100, 8'd102};
            if (obs !== exp_v) begin
               fails++;
               $display("FAIL drop_next_grant got %h exp %h", obs, exp_v);
            end
         end
      end
      tests++;
      if (wcnt != 8) begin
         fails++;
         $display("FAIL e2e_count got %0d exp %0d", wcnt, 8);
      end
      for (int k = 0; k < 8; k++) begin
         tests++;
         if (wlog[k] !== 8'(100 + k)) begin
            fails++;
            $display("FAIL e2e_word%0d got %0d exp %0d", k, wlog[k], 100 + k);
         end
      end
   endtask

   initial begin
      w_rst_n   = 1'b0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      full      = 1'b0;
      full_r    = 1'b0;
      en_mask   = 4'hF;
      wcnt      = 0;
      obs       = '0;
      exp_v     = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_full_stall();
      test_rr_pointer();
      test_reset_mid_burst();
      test_drop_end_to_end();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
